// File: rtl/huffman_stream_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// huffman_stream_packer : table-driven Huffman encoder packing MSB-first words
// Revision 1.0
// ----------------------------------------------------------------------------
module huffman_stream_packer #(
  parameter int SYM_WIDTH = 8,
  parameter int MAX_LEN   = 16,
  parameter int OUT_WIDTH = 32,
  parameter int LEN_W     = $clog2(MAX_LEN+1),
  parameter int BITS_W    = $clog2(OUT_WIDTH+1)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tbl_we_i,
  input  logic [SYM_WIDTH-1:0] tbl_addr_i,
  input  logic [MAX_LEN-1:0]   tbl_code_i,
  input  logic [LEN_W-1:0]     tbl_len_i,
  input  logic                 sym_valid_i,
  output logic                 sym_ready_o,
  input  logic [SYM_WIDTH-1:0] sym_i,
  input  logic                 sym_last_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [OUT_WIDTH-1:0] out_data_o,
  output logic [BITS_W-1:0]    out_bits_o,
  output logic                 out_last_o,
  output logic                 busy_o,
  output logic                 err_o
);

  localparam int NUM    = 2**SYM_WIDTH;
  localparam int ACC_W  = OUT_WIDTH + MAX_LEN;
  localparam int FILL_W = $clog2(ACC_W+1);

  localparam logic [1:0] ACCEPT = 2'd0;
  localparam logic [1:0] APPEND = 2'd1;
  localparam logic [1:0] EMIT   = 2'd2;
  localparam logic [1:0] FLUSH  = 2'd3;

  localparam logic [FILL_W-1:0] OUT_W_F = FILL_W'(OUT_WIDTH);

  logic [MAX_LEN-1:0] tbl_code_q [NUM];
  logic [LEN_W-1:0]   tbl_len_q  [NUM];
  logic [LEN_W-1:0]   tbl_len_wr;

  logic [1:0]         state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MAX_LEN-1:0] code_q, code_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               last_q, last_d;
  logic               err_q, err_d;

  logic [MAX_LEN-1:0] code_mask;
  logic [ACC_W-1:0]   code_aligned;
  logic [FILL_W-1:0]  fill_sum;
  logic [FILL_W-1:0]  fill_rem;

  assign tbl_len_wr = (tbl_len_i > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : tbl_len_i;

  // Table is deliberately unreset so a stream reset keeps the loaded codes.
  always_ff @(posedge clk_i) begin
    if (tbl_we_i && !busy_o) begin
      tbl_code_q[tbl_addr_i] <= tbl_code_i;
      tbl_len_q[tbl_addr_i]  <= tbl_len_wr;
    end
  end

  // Left-justify the masked code, then slide it down to the current fill point.
  assign code_mask    = ~({MAX_LEN{1'b1}} << len_q);
  assign code_aligned = ({code_q & code_mask, {(ACC_W-MAX_LEN){1'b0}}}
                         << (LEN_W'(MAX_LEN) - len_q)) >> fill_q;
  assign fill_sum     = fill_q + FILL_W'(len_q);
  assign fill_rem     = fill_q - OUT_W_F;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    fill_d  = fill_q;
    code_d  = code_q;
    len_d   = len_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      ACCEPT: begin
        if (sym_valid_i) begin
          code_d  = tbl_code_q[sym_i];
          len_d   = tbl_len_q[sym_i];
          last_d  = sym_last_i;
          state_d = APPEND;
        end
      end
      APPEND: begin
        acc_d  = acc_q | code_aligned;
        fill_d = fill_sum;
        if (len_q == '0) err_d = 1'b1;
        if (fill_sum >= OUT_W_F) state_d = EMIT;
        else if (last_q)         state_d = FLUSH;
        else                     state_d = ACCEPT;
      end
      EMIT: begin
        if (out_ready_i) begin
          acc_d  = acc_q << OUT_WIDTH;
          fill_d = fill_rem;
          if (last_q && fill_rem != '0) begin
            state_d = FLUSH;
          end else begin
            state_d = ACCEPT;
            last_d  = 1'b0;
          end
        end
      end
      default: begin
        if (out_ready_i) begin
          acc_d   = '0;
          fill_d  = '0;
          last_d  = 1'b0;
          state_d = ACCEPT;
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ACCEPT;
      acc_q   <= '0;
      fill_q  <= '0;
      code_q  <= '0;
      len_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      code_q  <= code_d;
      len_q   <= len_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Outputs decode registered state only; bits below fill are always zero.
  always_comb begin
    sym_ready_o = (state_q == ACCEPT);
    out_valid_o = (state_q == EMIT) || (state_q == FLUSH);
    out_data_o  = out_valid_o ? acc_q[ACC_W-1 -: OUT_WIDTH] : '0;
    out_bits_o  = '0;
    out_last_o  = 1'b0;
    if (state_q == EMIT) begin
      out_bits_o = BITS_W'(OUT_WIDTH);
      out_last_o = last_q && (fill_q == OUT_W_F);
    end else if (state_q == FLUSH) begin
      out_bits_o = BITS_W'(fill_q);
      out_last_o = 1'b1;
    end
  end

  assign busy_o = (state_q != ACCEPT) || (fill_q != '0);
  assign err_o  = err_q;

endmodule
`default_nettype wire

// File: tb/tb_huffman_stream_packer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_huffman_stream_packer : directed self-checking bench for the packer
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_huffman_stream_packer;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        tbl_we_i = 1'b0;
  logic [7:0]  tbl_addr_i = '0;
  logic [15:0] tbl_code_i = '0;
  logic [4:0]  tbl_len_i = '0;
  logic        sym_valid_i = 1'b0;
  logic        sym_ready_o;
  logic [7:0]  sym_i = '0;
  logic        sym_last_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_data_o;
  logic [5:0]  out_bits_o;
  logic        out_last_o;
  logic        busy_o;
  logic        err_o;

  int total = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  huffman_stream_packer dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .tbl_we_i    (tbl_we_i),
    .tbl_addr_i  (tbl_addr_i),
    .tbl_code_i  (tbl_code_i),
    .tbl_len_i   (tbl_len_i),
    .sym_valid_i (sym_valid_i),
    .sym_ready_o (sym_ready_o),
    .sym_i       (sym_i),
    .sym_last_i  (sym_last_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .out_bits_o  (out_bits_o),
    .out_last_o  (out_last_o),
    .busy_o      (busy_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write_tbl(input logic [7:0] a, input logic [15:0] c, input logic [4:0] l);
    @(negedge clk_i);
    tbl_we_i = 1'b1; tbl_addr_i = a; tbl_code_i = c; tbl_len_i = l;
    @(posedge clk_i);
    #1 tbl_we_i = 1'b0;
  endtask

  task automatic send_sym(input logic [7:0] s, input logic last);
    bit done = 0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk_i);
      if (sym_ready_o) begin
        sym_valid_i = 1'b1; sym_i = s; sym_last_i = last;
        @(posedge clk_i);
        #1 sym_valid_i = 1'b0; sym_last_i = 1'b0;
        done = 1;
      end
    end
    if (!done) check("send_timeout", 64'd0, 64'd1);
  endtask

  // Wait for a word, check it, optionally hold it stalled, then accept it.
  task automatic expect_word(input string tag, input logic [31:0] d, input logic [5:0] b,
                             input logic l, input int stall);
    bit seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk_i);
      if (out_valid_o) seen = 1;
    end
    if (!seen) begin
      check({tag, "_timeout"}, 64'd0, 64'd1);
      return;
    end
    check({tag, "_data"}, 64'(out_data_o), 64'(d));
    check({tag, "_bits"}, 64'(out_bits_o), 64'(b));
    check({tag, "_last"}, 64'(out_last_o), 64'(l));
    for (int i = 0; i < stall; i++) begin
      @(negedge clk_i);
      check({tag, "_hold"}, {out_valid_o, sym_ready_o, out_last_o, out_bits_o, out_data_o},
            {1'b1, 1'b0, l, b, d});
    end
    @(negedge clk_i);
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1 out_ready_i = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk_i);
    check({tag, "_idle"}, {61'd0, out_valid_o, busy_o, sym_ready_o}, 64'b001);
  endtask

  initial begin
    #1;
    check("rst_outputs", {sym_ready_o, out_valid_o, out_last_o, busy_o, err_o, out_bits_o, out_data_o},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 6'd0, 32'd0});
    @(negedge clk_i);
    rst_ni = 1'b1;

    write_tbl(8'h61, 16'h0000, 5'd1);
    write_tbl(8'h62, 16'h0002, 5'd2);
    write_tbl(8'h63, 16'h0003, 5'd2);
    write_tbl(8'h10, 16'hABCD, 5'd16);
    write_tbl(8'h11, 16'h1234, 5'd16);
    write_tbl(8'h12, 16'hFFFF, 5'd31);   // clamped to 16
    write_tbl(8'h13, 16'hFFFF, 5'd0);    // masked to nothing

    // 0 | 10 | 11 -> 01011 left-justified
    send_sym(8'h61, 1'b0);
    send_sym(8'h62, 1'b0);
    send_sym(8'h63, 1'b1);
    expect_word("abc", 32'h5800_0000, 6'd5, 1'b1, 0);
    expect_idle("abc");

    send_sym(8'h10, 1'b0);
    send_sym(8'h11, 1'b1);
    expect_word("exact", 32'hABCD_1234, 6'd32, 1'b1, 0);
    expect_idle("exact");

    send_sym(8'h12, 1'b0);
    send_sym(8'h12, 1'b0);
    expect_word("ff_w0", 32'hFFFF_FFFF, 6'd32, 1'b0, 0);
    send_sym(8'h12, 1'b1);
    expect_word("ff_w1", 32'hFFFF_0000, 6'd16, 1'b1, 0);
    expect_idle("ff");

    send_sym(8'h12, 1'b0);
    send_sym(8'h12, 1'b0);
    expect_word("st_w0", 32'hFFFF_FFFF, 6'd32, 1'b0, 5);
    send_sym(8'h12, 1'b1);
    expect_word("st_w1", 32'hFFFF_0000, 6'd16, 1'b1, 5);
    expect_idle("st");

    check("err_before", 64'(err_o), 64'd0);
    send_sym(8'h13, 1'b1);
    expect_word("len0", 32'h0000_0000, 6'd0, 1'b1, 0);
    check("err_set", 64'(err_o), 64'd1);
    repeat (3) @(negedge clk_i);
    check("err_sticky", 64'(err_o), 64'd1);

    // Mid-stream: the write must be ignored, then reset drops the partial bit.
    send_sym(8'h61, 1'b0);
    @(negedge clk_i);
    check("busy_mid", 64'(busy_o), 64'd1);
    write_tbl(8'h61, 16'h0001, 5'd1);
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    check("rst_mid", {59'd0, out_valid_o, busy_o, sym_ready_o, err_o, out_last_o},
          {59'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0});
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_sym(8'h61, 1'b0);
    send_sym(8'h62, 1'b0);
    send_sym(8'h63, 1'b1);
    expect_word("rerun", 32'h5800_0000, 6'd5, 1'b1, 0);
    expect_idle("rerun");

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/huffman_stream_packer.md
# huffman_stream_packer

Table-driven Huffman stream encoder and bit packer. A host loads a symbol→(codeword, length) table. The block then accepts a symbol stream over a valid/ready handshake, concatenates the variable-length codewords MSB-first, and emits fixed-width output words with a final partial word flagged as last. It sits after code-table generation, replacing bit-serial text output with a parametrised, back-pressurable word stream.

## Interface
- SYM_WIDTH, 8, symbol width; table depth is 2**SYM_WIDTH
- MAX_LEN, 16, maximum codeword length in bits; must be ≤ OUT_WIDTH
- OUT_WIDTH, 32, output word width
- LEN_W, $clog2(MAX_LEN+1), width of length fields
- BITS_W, $clog2(OUT_WIDTH+1), width of out_bits_o
---
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous, active-low reset
- tbl_we_i  in  1  table write strobe
- tbl_addr_i  in  SYM_WIDTH  symbol being written
- tbl_code_i  in  MAX_LEN  codeword, right-aligned
- tbl_len_i  in  LEN_W  codeword length
- sym_valid_i  in  1  input symbol valid
- sym_ready_o  out  1  input symbol accepted when valid&&ready
- sym_i  in  SYM_WIDTH  symbol
- sym_last_i  in  1  final symbol of stream
- out_valid_o  out  1  output word valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  OUT_WIDTH  packed bits; first bit at MSB
- out_bits_o  out  BITS_W  number of meaningful bits in out_data_o
- out_last_o  out  1  last word of stream
- busy_o  out  1  stream in progress
- err_o  out  1  sticky: a length-0 symbol was encoded

## Operation
- Table: register array, NUM = 2**SYM_WIDTH entries, not reset.
  - A write is taken when tbl_we_i=1 and busy_o=0. Writes while busy_o=1 are ignored.
  - tbl_len_i > MAX_LEN is clamped to MAX_LEN at write.
  - Code bits above len are masked off at append.
- Accumulator acc is OUT_WIDTH+MAX_LEN bits, left-aligned. fill is the number of valid bits.
- State machine, reset state ACCEPT:
  - ACCEPT: sym_ready_o=1. On handshake, register code_q/len_q from the table and last_q←sym_last_i; go to APPEND.
  - APPEND: OR the masked code into acc at bit position (ACC_W−1−fill), MSB of code first; fill += len_q. Set err_o if len_q=0.
    - fill ≥ OUT_WIDTH → EMIT.
    - else last_q → FLUSH.
    - else → ACCEPT.
  - EMIT: out_valid_o=1, out_data_o=acc[top OUT_WIDTH], out_bits_o=OUT_WIDTH, out_last_o=last_q && fill==OUT_WIDTH. On out_ready_i: acc<<=OUT_WIDTH, fill−=OUT_WIDTH.
    - last_q && remaining fill>0 → FLUSH.
    - otherwise → ACCEPT, clearing last_q.
  - FLUSH: out_valid_o=1, out_data_o=top bits zero-padded, out_bits_o=fill (0 allowed), out_last_o=1. On out_ready_i: acc=0, fill=0, last_q=0 → ACCEPT.
- busy_o = (state≠ACCEPT) || fill≠0.
- err_o is cleared only by reset.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) forces:
  - state=ACCEPT, fill=0, acc=0.
  - sym_ready_o=1, out_valid_o=0, out_data_o=0, out_bits_o=0, out_last_o=0, busy_o=0, err_o=0.
  - Table contents retained.
- Reset mid-stream discards all partial bits. No output word is produced for them.
- Symbol throughput is one per 2 cycles (ACCEPT, APPEND), plus ≥1 cycle for each EMIT/FLUSH word.
- Latency from the symbol handshake that completes a word to out_valid_o=1 is 2 clocks.
- sym_ready_o and out_valid_o are decoded from registered state only; there is no combinational in→out path.
- While out_valid_o=1 && out_ready_i=0, out_data_o/out_bits_o/out_last_o are held stable, and sym_ready_o=0.
- Since MAX_LEN ≤ OUT_WIDTH, at most one full word exists per symbol. fill < OUT_WIDTH after EMIT.
- A table write in the same cycle as a symbol handshake in ACCEPT (busy_o=0): the lookup uses the old entry, and the write takes effect next cycle.

## Test plan
- Default params; table 0x61→(0b0,1), 0x62→(0b10,2), 0x63→(0b11,2); stream 61,62,63(last) -> single word 0x58000000, out_bits_o=5, out_last_o=1.
- Symbols (0xABCD,16),(0x1234,16 last) -> one word 0xABCD1234, out_bits_o=32, out_last_o=1; no extra FLUSH word.
- Three symbols (0xFFFF,16), last on third -> 0xFFFFFFFF/bits 32/last 0, then 0xFFFF0000/bits 16/last 1.
- Repeat the previous case with out_ready_i=0 for 5 cycles at each word -> outputs held stable, sym_ready_o=0 throughout, identical word sequence.
- Single symbol with len 0, last -> err_o=1 and stays 1; word 0x00000000, out_bits_o=0, out_last_o=1.
- Write 0x61→(0b1,1) while busy_o=1 is ignored; assert rst_ni low mid-stream -> out_valid_o=0, busy_o=0; rerunning the first case yields 0x58000000/5/last.
